// File: rtl/f_fetch_unit_pkg.sv
// Shared types and constants for the MIPS F stage.
// Holds the reset PC, FSM encoding, F/D bundle and jump-field widths.
package f_fetch_unit_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  localparam int INDEX_W = 26;
  localparam int IMM_W   = 16;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } f_state_e;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] br_offset(
    input logic [IMM_W-1:0] imm
  );
    return {{14{imm[IMM_W-1]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/f_fetch_unit_npc.sv
// Redirect target select for the instruction leaving D.
// Priority jr > j/jal > taken branch; all arithmetic wraps at 32 bits.
module f_npc
  import f_fetch_unit_pkg::*;
(
  input  logic [31:0]        pc_d,
  input  logic [IMM_W-1:0]   imm16,
  input  logic [INDEX_W-1:0] instr_index,
  input  logic [31:0]        rs_val,
  input  logic               jr,
  input  logic               jump,
  input  logic               br,
  output logic               redirect,
  output logic [31:0]        target
);

  logic [31:0] br_tgt;
  logic [31:0] j_tgt;

  assign br_tgt = pc_d + 32'd4 + br_offset(imm16);
  assign j_tgt  = {pc_d[31:28], instr_index, 2'b00};

  always_comb begin
    redirect = jr | jump | br;
    target   = pc_d + 32'd4;
    priority case (1'b1)
      jr:      target = rs_val;
      jump:    target = j_tgt;
      br:      target = br_tgt;
      default: target = pc_d + 32'd4;
    endcase
  end

endmodule

// File: rtl/f_fetch_unit.sv
// F stage: owns PC_F, talks to instruction memory, loads F/D.
// A redirect waits in tgt_pend until the delay slot is loaded.
module f_fetch_unit
  import f_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               br_D,
  input  logic [IMM_W-1:0]   imm16_D,
  input  logic               jump_D,
  input  logic [INDEX_W-1:0] instr_index_D,
  input  logic               jr_D,
  input  logic [31:0]        rs_val_D,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_valid,
  output logic [31:0]        IR_D,
  output logic [31:0]        PC_D,
  output logic [31:0]        PC8_D,
  output logic               valid_D
);

  f_state_e    state_q;
  f_state_e    state_d;
  logic [31:0] pc_f_q;
  logic [31:0] hold_q;
  logic        tgt_pend_q;
  logic [31:0] tgt_addr_q;
  if_id_t      fd_q;

  logic        load;
  logic        latch_hold;
  logic        bubble;
  logic [31:0] fd_word;
  logic        leave;
  logic        redirect;
  logic        raise;
  logic [31:0] target;
  logic [31:0] npc;

  f_npc u_npc (
    .pc_d        (fd_q.pc),
    .imm16       (imm16_D),
    .instr_index (instr_index_D),
    .rs_val      (rs_val_D),
    .jr          (jr_D),
    .jump        (jump_D),
    .br          (br_D),
    .redirect    (redirect),
    .target      (target)
  );

  assign leave = fd_q.valid & ~stall;
  assign raise = leave & redirect;

  // same-cycle raise bypasses the pending register
  always_comb begin
    npc = pc_f_q + 32'd4;
    if (raise)
      npc = target;
    else if (tgt_pend_q)
      npc = tgt_addr_q;
  end

  always_comb begin
    state_d    = state_q;
    load       = 1'b0;
    latch_hold = 1'b0;
    bubble     = 1'b0;
    fd_word    = imem_rdata;
    imem_req   = 1'b0;
    unique case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_valid && !stall) begin
          load = 1'b1;
        end else if (imem_valid) begin
          latch_hold = 1'b1;
          state_d    = HOLD;
        end else if (!stall) begin
          bubble = 1'b1;
        end
      end
      HOLD: begin
        if (!stall) begin
          load    = 1'b1;
          fd_word = hold_q;
          state_d = FETCH;
        end
      end
    endcase
  end

  assign imem_addr = pc_f_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      pc_f_q  <= RESET_PC;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load)
        pc_f_q <= npc;
      if (latch_hold)
        hold_q <= imem_rdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fd_q.ir    <= '0;
      fd_q.pc    <= '0;
      fd_q.pc8   <= 32'd8;
      fd_q.valid <= 1'b0;
    end else if (load) begin
      fd_q.ir    <= fd_word;
      fd_q.pc    <= pc_f_q;
      fd_q.pc8   <= pc_f_q + 32'd8;
      fd_q.valid <= 1'b1;
    end else if (bubble) begin
      fd_q.valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tgt_pend_q <= 1'b0;
      tgt_addr_q <= '0;
    end else if (load) begin
      tgt_pend_q <= 1'b0;
    end else if (raise) begin
      tgt_pend_q <= 1'b1;
      tgt_addr_q <= target;
    end
  end

  assign IR_D    = fd_q.ir;
  assign PC_D    = fd_q.pc;
  assign PC8_D   = fd_q.pc8;
  assign valid_D = fd_q.valid;

endmodule
